// File: rtl/pwm_pkg.sv
// Shared PWM definitions, used by both the PWM generator and the capture block.
package pwm_pkg;

  localparam int PWM_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous PWM input into the clk domain and produces
// single-cycle rise/fall strobes. A rise is only reported once the input has been seen low.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   s_d_q, s_d_d;
  logic                   armed_q, armed_d;

  // fill tracks when the chain holds real samples, so the reset zeros flushing out
  // of it cannot arm the detector while pwm_in is actually high.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    s_d_d   = s;
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      s_d_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      s_d_q   <= s_d_d;
      armed_q <= armed_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q & armed_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period (rising edge to rising edge) of an incoming PWM
// waveform, publishing each completed period and flagging a stuck input after a timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int          CNT_W       = PWM_CNT_W,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  if (TIMEOUT < 2 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT must lie in 2 .. 2**CNT_W-1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pwm_capture: SYNC_STAGES must be at least 2");
  end

  logic s, rise, fall;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_cap_state_t   state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;
  logic             timeout;

  assign timeout = (pcnt_q == CNT_W'(TIMEOUT));

  // Timeout is checked before counting, so pcnt stops at TIMEOUT and never wraps.
  // A rise in LOW takes priority, so a period of exactly TIMEOUT is still published.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    pcnt_d       = pcnt_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    if (!en) begin
      state_d = IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
    end else begin
      if (rise) begin
        stuck_high_d = 1'b0;
        stuck_low_d  = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            hcnt_d  = CNT_W'(1);
            pcnt_d  = CNT_W'(1);
          end
        end
        HIGH: begin
          if (timeout) begin
            state_d      = IDLE;
            stuck_high_d = s;
            stuck_low_d  = ~s;
          end else if (fall) begin
            state_d = LOW;
            pcnt_d  = pcnt_q + CNT_W'(1);
          end else if (s) begin
            hcnt_d = hcnt_q + CNT_W'(1);
            pcnt_d = pcnt_q + CNT_W'(1);
          end
        end
        LOW: begin
          if (rise) begin
            high_time_d  = hcnt_q;
            period_d     = pcnt_q;
            meas_valid_d = 1'b1;
            state_d      = HIGH;
            hcnt_d       = CNT_W'(1);
            pcnt_d       = CNT_W'(1);
          end else if (timeout) begin
            state_d      = IDLE;
            stuck_high_d = s;
            stuck_low_d  = ~s;
          end else if (!s) begin
            pcnt_d = pcnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hcnt_q       <= '0;
      pcnt_q       <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      pcnt_q       <= pcnt_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign high_time  = high_time_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule
